// File: rtl/uart_defs.sv
// Shared definitions for the UART transmit path: parity selectors, FSM state
// encoding and the width of the baud-period counter.
// No ports (package).
package uart_defs;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int CLK_CNT_W = 16;
    localparam int BIT_IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Narrows an integer cycle count to the clk_cnt counter width.
    function automatic logic [CLK_CNT_W-1:0] clk_cnt_val(input int value);
        return value[CLK_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and first-word
// fall-through read data (pop_data shows the head word whenever not empty).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write strobe and word (ignored when full)
//   pop             read strobe, consumes pop_data (ignored when empty)
//   pop_data        head word
//   full, empty     registered status flags
//   count           words stored, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CW'(1);
        end
    end

    // Flags are computed from the next count so they stay registered yet
    // never lag the pointers by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal FIFO; frames leave back-to-back while
// the FIFO holds data.
// Ports:
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   tx_valid, tx_data  byte offered (bits above DATA_BITS-1 ignored)
//   tx_ready           FIFO can accept this cycle
//   fifo_level         bytes queued, excluding the frame on the line
//   tx_busy            frame on the line or FIFO non-empty
//   uart_txd           registered serial output, idle high
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | line high, waiting for the FIFO to hold a byte
// ST_START  | start bit (low)
// ST_DATA   | data bits, LSB first, shifted out of shreg
// ST_PARITY | parity bit (only when PARITY != 0)
// ST_STOP   | stop bit(s); bit_idx counts stop bits here
module uart_tx_fifo
    import uart_defs::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_data,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_busy,
    output logic                          uart_txd
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam logic [CLK_CNT_W-1:0] BPS_LAST  = clk_cnt_val(BPS_CNT - 1);
    localparam logic [BIT_IDX_W-1:0] DATA_LAST = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] STOP_LAST = BIT_IDX_W'(STOP_BITS - 1);
    localparam logic [7:0]           DATA_MASK = 8'((1 << DATA_BITS) - 1);

    if (BPS_CNT < 2 || BPS_CNT > 65535) begin : g_bad_bps
        $error("uart_tx_fifo: CLK_FREQ/UART_BPS must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t             state, state_next;
    logic [CLK_CNT_W-1:0]  clk_cnt, clk_cnt_next;
    logic [BIT_IDX_W-1:0]  bit_idx, bit_idx_next;
    logic [7:0]            shreg, shreg_next;
    logic                  par_bit, par_bit_next;
    logic                  txd_next;
    logic                  busy_next;
    logic                  ready_q;
    logic                  push;
    logic                  pop;
    logic                  start_frame;
    logic                  bit_last;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [7:0]            fifo_data;
    logic [7:0]            load_data;

    // ready_q holds tx_ready low through reset and releases it on the first
    // edge afterwards; the rest of tx_ready comes from registered FIFO state.
    assign tx_ready  = ready_q && !fifo_full;
    assign push      = tx_valid && tx_ready;
    assign load_data = fifo_data & DATA_MASK;
    assign bit_last  = (clk_cnt == BPS_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (push),
        .push_data (tx_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_level)
    );

    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt + CLK_CNT_W'(1);
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        par_bit_next = par_bit;
        txd_next     = uart_txd;
        start_frame  = 1'b0;
        pop          = 1'b0;

        case (state)
            ST_IDLE: begin
                clk_cnt_next = '0;
                txd_next     = 1'b1;
                start_frame  = !fifo_empty;
            end
            ST_START: begin
                if (bit_last) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = ST_DATA;
                    txd_next     = shreg[0];
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    clk_cnt_next = '0;
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_next = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_next = ST_PARITY;
                            txd_next   = par_bit;
                        end else begin
                            state_next = ST_STOP;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        bit_idx_next = bit_idx + BIT_IDX_W'(1);
                        shreg_next   = {1'b0, shreg[7:1]};
                        txd_next     = shreg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_last) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = ST_STOP;
                    txd_next     = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    clk_cnt_next = '0;
                    if (bit_idx == STOP_LAST) begin
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        bit_idx_next = bit_idx + BIT_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                txd_next   = 1'b1;
            end
        endcase

        // Shared by IDLE and the last stop cycle so consecutive frames touch.
        if (start_frame) begin
            pop          = 1'b1;
            shreg_next   = load_data;
            par_bit_next = (PARITY == PARITY_ODD) ? ~^load_data : ^load_data;
            state_next   = ST_START;
            clk_cnt_next = '0;
            txd_next     = 1'b0;
        end

        // The FIFO can only be non-empty after this edge while the FSM sits in
        // IDLE if a byte is being pushed right now.
        busy_next = (state_next != ST_IDLE) || push;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_next;
            clk_cnt  <= clk_cnt_next;
            bit_idx  <= bit_idx_next;
            shreg    <= shreg_next;
            par_bit  <= par_bit_next;
            uart_txd <= txd_next;
            tx_busy  <= busy_next;
            ready_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1 depth 4, 8E2, 8O1, 5N1 depth 8)
// share clock and reset. Each has a queue-based line model; a compare process
// checks every output of every instance on each falling edge, and the main
// sequence adds literal expectations for the directed cases.
module tb_uart_tx_fifo;

    localparam int NI  = 4;
    localparam int BPS = 10;
    localparam int DB  [NI] = '{8, 8, 8, 5};
    localparam int PAR [NI] = '{0, 2, 1, 0};
    localparam int SB  [NI] = '{1, 2, 1, 1};
    localparam int DEP [NI] = '{4, 16, 16, 8};

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       valid_a [NI];
    logic [7:0] data_a  [NI];
    logic       txd_a   [NI];
    logic       ready_a [NI];
    logic       busy_a  [NI];
    logic [4:0] lvl_a   [NI];
    logic       exp_txd   [NI];
    logic       exp_ready [NI];
    logic       exp_busy  [NI];
    int         exp_lvl   [NI];

    int n_checks = 0;
    int n_errors = 0;

    int   len [NI];
    logic tr  [NI][256];

    always #5 sys_clk = ~sys_clk;

    task automatic check_int(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s inst=%0d t=%0t: actual %0d, required %0d", name, inst, $time, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input int inst, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst=%0d t=%0t: actual %b, required %b", name, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LW = $clog2(DEP[g]) + 1;

        logic          txd_w, ready_w, busy_w;
        logic [LW-1:0] lvl_w;

        logic [7:0] bq [$];
        logic       cq [$];
        logic       in_frame = 1'b0;
        logic       ready_ok = 1'b0;
        logic       m_txd    = 1'b1;
        int         m_lvl    = 0;
        logic       m_acc;
        logic [7:0] m_b;
        logic       m_p;

        uart_tx_fifo #(
            .CLK_FREQ   (1000000),
            .UART_BPS   (100000),
            .DATA_BITS  (DB[g]),
            .PARITY     (PAR[g]),
            .STOP_BITS  (SB[g]),
            .FIFO_DEPTH (DEP[g])
        ) u_dut (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .tx_valid   (valid_a[g]),
            .tx_data    (data_a[g]),
            .tx_ready   (ready_w),
            .fifo_level (lvl_w),
            .tx_busy    (busy_w),
            .uart_txd   (txd_w)
        );

        assign txd_a[g]     = txd_w;
        assign ready_a[g]   = ready_w;
        assign busy_a[g]    = busy_w;
        assign lvl_a[g]     = 5'(lvl_w);
        assign exp_txd[g]   = m_txd;
        assign exp_ready[g] = ready_ok && (m_lvl < DEP[g]);
        assign exp_busy[g]  = in_frame || (m_lvl > 0);
        assign exp_lvl[g]   = m_lvl;

        // bq: bytes waiting; cq: expected line level for each remaining cycle
        // of the frame in flight.
        initial forever begin
            @(posedge sys_clk or posedge sys_rst);
            if (sys_rst) begin
                bq.delete();
                cq.delete();
                in_frame = 1'b0;
                ready_ok = 1'b0;
                m_txd    = 1'b1;
                m_lvl    = 0;
            end else begin
                m_acc = valid_a[g] && ready_ok && (bq.size() < DEP[g]);
                if (cq.size() == 0 && bq.size() > 0) begin
                    m_b = bq.pop_front();
                    m_p = 1'b0;
                    for (int j = 0; j < DB[g]; j++) m_p ^= m_b[j];
                    if (PAR[g] == 1) m_p = ~m_p;
                    for (int k = 0; k < BPS; k++) cq.push_back(1'b0);
                    for (int j = 0; j < DB[g]; j++)
                        for (int k = 0; k < BPS; k++) cq.push_back(m_b[j]);
                    if (PAR[g] != 0)
                        for (int k = 0; k < BPS; k++) cq.push_back(m_p);
                    for (int k = 0; k < SB[g] * BPS; k++) cq.push_back(1'b1);
                end
                if (cq.size() > 0) begin
                    m_txd    = cq.pop_front();
                    in_frame = 1'b1;
                end else begin
                    m_txd    = 1'b1;
                    in_frame = 1'b0;
                end
                if (m_acc) bq.push_back(data_a[g]);
                m_lvl    = bq.size();
                ready_ok = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge sys_clk);
        for (int i = 0; i < NI; i++) begin
            check_bit("uart_txd", i, txd_a[i], exp_txd[i]);
            check_bit("tx_ready", i, ready_a[i], exp_ready[i]);
            check_bit("tx_busy", i, busy_a[i], exp_busy[i]);
            check_int("fifo_level", i, int'(lvl_a[i]), exp_lvl[i]);
        end
    end

    task automatic capture(input int n);
        for (int i = 0; i < NI; i++) len[i] = -1;
        for (int k = 1; k <= n; k++) begin
            @(posedge sys_clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                tr[i][k] = txd_a[i];
                if (len[i] < 0 && !busy_a[i]) len[i] = k - 1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic       acc;
        logic       done;
        int         nb;
        int         peak;
        int         k;
        int         lim [3];

        for (int i = 0; i < NI; i++) begin
            valid_a[i] = 1'b0;
            data_a[i]  = 8'h00;
        end
        repeat (3) @(posedge sys_clk);
        #1;
        check_bit("ready_in_reset", 0, ready_a[0], 1'b0);
        check_bit("txd_in_reset", 0, txd_a[0], 1'b1);
        sys_rst = 1'b0;
        check_bit("ready_before_first_edge", 0, ready_a[0], 1'b0);
        @(posedge sys_clk);
        #1;
        check_bit("ready_after_release", 0, ready_a[0], 1'b1);

        // One frame on every instance: 0x55 8N1, 0xA7 8E2 / 8O1, 0xFF 5N1.
        data_a[0] = 8'h55;
        data_a[1] = 8'hA7;
        data_a[2] = 8'hA7;
        data_a[3] = 8'hFF;
        for (int i = 0; i < NI; i++) valid_a[i] = 1'b1;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < NI; i++) valid_a[i] = 1'b0;
        capture(130);

        check_bit("a_start_first", 0, tr[0][1], 1'b0);
        check_bit("a_start_last", 0, tr[0][10], 1'b0);
        v = 8'h55;
        for (int j = 0; j < 8; j++) check_bit("a_data", 0, tr[0][16 + 10 * j], v[j]);
        check_bit("a_stop", 0, tr[0][95], 1'b1);
        check_int("a_frame_len", 0, len[0], 100);
        v = 8'hA7;
        for (int j = 0; j < 8; j++) check_bit("b_data", 1, tr[1][16 + 10 * j], v[j]);
        check_bit("b_even_parity", 1, tr[1][95], 1'b1);
        check_bit("b_stop2", 1, tr[1][115], 1'b1);
        check_int("b_frame_len", 1, len[1], 120);
        check_bit("c_odd_parity", 2, tr[2][95], 1'b0);
        check_bit("c_stop", 2, tr[2][105], 1'b1);
        check_int("c_frame_len", 2, len[2], 110);
        for (int j = 0; j < 5; j++) check_bit("d_data", 3, tr[3][16 + 10 * j], 1'b1);
        check_bit("d_stop", 3, tr[3][65], 1'b1);
        check_int("d_frame_len", 3, len[3], 70);

        // Hold tx_valid for bytes 0x01..0x06 into the depth-4 instance.
        nb         = 1;
        peak       = 0;
        k          = -1;
        done       = 1'b0;
        data_a[0]  = 8'h01;
        valid_a[0] = 1'b1;
        for (int c = 0; c < 1000 && !done; c++) begin
            acc = valid_a[0] && ready_a[0];
            @(posedge sys_clk);
            #1;
            k++;
            if (acc) begin
                nb++;
                if (nb > 6) valid_a[0] = 1'b0;
                else data_a[0] = 8'(nb);
            end
            if (int'(lvl_a[0]) > peak) peak = int'(lvl_a[0]);
            if (!valid_a[0] && !busy_a[0]) done = 1'b1;
        end
        check_int("burst_peak_level", 0, peak, 4);
        check_int("burst_busy_span", 0, k, 601);

        // Random traffic at three offered loads, then drain.
        lim = '{3, 60, 200};
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 1000; c++) begin
                for (int i = 0; i < NI; i++) begin
                    valid_a[i] = ($urandom_range(0, lim[ph]) == 0);
                    data_a[i]  = 8'($urandom);
                end
                @(posedge sys_clk);
                #1;
            end
        end
        for (int i = 0; i < NI; i++) valid_a[i] = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(posedge sys_clk);
            #1;
            done = 1'b1;
            for (int i = 0; i < NI; i++) if (busy_a[i]) done = 1'b0;
        end
        check_bit("drain_completes", -1, done, 1'b1);

        // Three-byte burst, reset asserted in the middle of the first frame's data.
        valid_a[0] = 1'b1;
        data_a[0]  = 8'h11;
        @(posedge sys_clk);
        #1;
        data_a[0] = 8'h22;
        @(posedge sys_clk);
        #1;
        data_a[0] = 8'h33;
        @(posedge sys_clk);
        #1;
        valid_a[0] = 1'b0;
        repeat (30) @(posedge sys_clk);
        #2;
        check_bit("pre_reset_txd_low", 0, txd_a[0], 1'b0);
        sys_rst = 1'b1;
        #1;
        check_bit("reset_txd", 0, txd_a[0], 1'b1);
        check_int("reset_level", 0, int'(lvl_a[0]), 0);
        check_bit("reset_busy", 0, busy_a[0], 1'b0);
        check_bit("reset_ready", 0, ready_a[0], 1'b0);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        check_bit("release_ready_low", 0, ready_a[0], 1'b0);
        @(posedge sys_clk);
        #1;
        check_bit("release_ready_high", 0, ready_a[0], 1'b1);
        check_int("release_level", 0, int'(lvl_a[0]), 0);

        data_a[0]  = 8'h3C;
        valid_a[0] = 1'b1;
        @(posedge sys_clk);
        #1;
        valid_a[0] = 1'b0;
        capture(110);
        check_bit("post_reset_start", 0, tr[0][5], 1'b0);
        v = 8'h3C;
        for (int j = 0; j < 8; j++) check_bit("post_reset_data", 0, tr[0][16 + 10 * j], v[j]);
        check_int("post_reset_len", 0, len[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO, selectable data width, parity and stop bits. It replaces the single-byte, edge-triggered bus UART sender. Bus-side logic pushes bytes with a valid/ready handshake instead of a level-to-pulse enable. Frames are sent back-to-back from the FIFO with no idle gap, which frees the CPU from polling a busy flag per byte.

## Interface
- CLK_FREQ, 27000000, system clock frequency in Hz
- UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer division), legal range 2..65535
- DATA_BITS, 8, data bits per frame, 5..8
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, power of two, ≥ 2
- Clock and reset: one clock; reset is asynchronous and active-high.
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous active-high reset
- tx_valid  in  1  byte on tx_data offered for transmission
- tx_data  in  8  byte to send; bits above DATA_BITS-1 ignored
- tx_ready  out  1  FIFO can accept; transfer on rising sys_clk when tx_valid && tx_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently queued (not counting the frame in flight)
- tx_busy  out  1  a frame is on the line or the FIFO is non-empty
- uart_txd  out  1  serial output, idle high

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. The FSM drives a registered uart_txd.
- IDLE: uart_txd = 1. If the FIFO is non-empty, pop the head into a shift register, go to START.
- START: uart_txd = 0 for BPS_CNT cycles, then go to DATA.
- DATA: DATA_BITS bits, LSB first, BPS_CNT cycles each. Then go to PARITY if PARITY != 0, else STOP.
- PARITY: odd = ~^data[DATA_BITS-1:0]; even = ^data[DATA_BITS-1:0]; lasts BPS_CNT cycles.
- STOP: uart_txd = 1 for STOP_BITS×BPS_CNT cycles. On the final cycle:
  - FIFO non-empty: pop and go directly to START (no idle gap).
  - FIFO empty: go to IDLE.
- Bit counter: clk_cnt counts 0..BPS_CNT-1; it is 16 bits wide. Bit index counter is 4 bits wide.
- tx_ready = !full, derived from registered FIFO state. It has no combinational path from the pop.
- Push and pop on the same edge leave fifo_level unchanged.
- Full: tx_ready = 0 and tx_valid is ignored. A pop in that cycle raises tx_ready the next cycle.
- Empty with no push: FSM stays in IDLE.
- Reset (any time, including mid-frame):
  - FIFO emptied, FSM to IDLE.
  - uart_txd = 1, tx_busy = 0, fifo_level = 0, tx_ready = 0 while sys_rst is high.
  - A frame in flight is truncated; a truncated frame is acceptable.

## Timing
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × BPS_CNT cycles exactly.
- Latency: byte accepted at edge E into an empty FIFO with the FSM idle → FSM pops at E+1 → uart_txd low from E+1 onward.
- Back-to-back frames: next start bit begins on the cycle after the last stop-bit cycle.
- tx_ready rises on the first edge after sys_rst deasserts.
- fifo_level updates on the edge following push/pop.
- tx_busy rises with the first push. It falls on the edge where the FSM enters IDLE with the FIFO empty.

## Structure
- Shared package uart_defs:
  - PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2.
  - FSM state encodings.
  - Width helper for the clk_cnt counter.
- Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH):
  - Single-clock, registered full/empty/count.
  - Read data valid on the pop edge (first-word fall-through).
  - Reused later by the receive side.
- Elaboration-time checks: BPS_CNT ≥ 2; DATA_BITS in 5..8; PARITY ≤ 2; STOP_BITS in {1,2}; FIFO_DEPTH a power of two.

## Test plan
Bench parameters: CLK_FREQ = 1000000, UART_BPS = 100000, so BPS_CNT = 10.
- Default 8N1, push 0x55 once:
  - uart_txd low from E+1 for 10 cycles.
  - Data bits 1,0,1,0,1,0,1,0, each 10 cycles.
  - High stop bit; tx_busy falls at cycle 100 after the start.
- 8E2 and 8O1, push 0xA7 (five ones):
  - Even: parity bit = 1, then 20 cycles of stop.
  - Odd: parity bit = 0.
  - Frame lengths 120 and 110 cycles.
- DATA_BITS = 5, push 0xFF:
  - Only 5 data bits sent.
  - Frame = 70 cycles; upper tx_data bits ignored.
- FIFO_DEPTH = 4, hold tx_valid for 6 bytes 0x01..0x06:
  - tx_ready drops after the queue fills; fifo_level peaks at 4.
  - Each blocked byte is accepted one cycle after a pop.
  - All 6 frames are contiguous with no idle cycles; output order matches push order.
- Assert sys_rst mid-DATA of a 3-byte burst:
  - uart_txd = 1 immediately; fifo_level = 0; tx_busy = 0.
  - After release, tx_ready = 1 and a new push 0x3C transmits correctly.
